// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate_checker built-in self-test block.
//   state_t  : sweep FSM states
//   TT_*     : truth tables for common 2-input gates; bit i is the expected
//              output for input vector i (vector = {a, b}).
package gate_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_checker.sv
// Built-in checker for an N-input combinational gate. On start it drives
// every input vector in ascending order, waits SETTLE cycles, samples the
// gate output, and compares it with the EXPECT truth table.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            begin a sweep (only honoured in IDLE)
//   dut_in           registered vector to the gate under test
//   dut_y            gate output (combinational from dut_in, not synchronised)
//   busy             high while a sweep is in progress (DRIVE..DONE)
//   done             one-cycle pulse in the final cycle of a sweep
//   pass             1 when the last completed sweep had no mismatches
//   err_cnt          saturating mismatch count of the last/current sweep
//   first_fail_vec   first mismatching vector of the sweep
//   first_fail_valid first_fail_vec holds a real failure
module gate_checker
   import gate_check_pkg::*;
#(
   parameter int                  N_IN   = 2,
   parameter int                  SETTLE = 1,
   parameter logic [2**N_IN-1:0]  EXPECT = TT_OR2,
   parameter int                  ERR_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic              dut_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [N_IN-1:0]   first_fail_vec,
   output logic              first_fail_valid
);

   // Settle counter counts 0..SETTLE-1 while in the SETTLE state and is
   // incremented once more on the exit edge, so it must hold SETTLE.
   localparam int              CNT_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  VEC_LAST = '1;

   state_t            state;
   logic [N_IN-1:0]   vec;
   logic [CNT_W-1:0]  settle_cnt;
   logic              mismatch;

   assign mismatch = (dut_y != EXPECT[vec]);

   // The parameter SETTLE shadows the package state of the same name inside
   // this module, so that state is always referenced with its package scope.

   // NOTE: every register here is assigned with <= so all state updates see
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         vec              <= '0;
         settle_cnt       <= '0;
         dut_in           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_cnt          <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state            <= DRIVE;
                  busy             <= 1'b1;
                  vec              <= '0;
                  err_cnt          <= '0;
                  pass             <= 1'b0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
               end
            end

            DRIVE: begin
               dut_in     <= vec;
               settle_cnt <= '0;
               state      <= (SETTLE > 0) ? gate_check_pkg::SETTLE : SAMPLE;
            end

            gate_check_pkg::SETTLE: begin
               settle_cnt <= settle_cnt + CNT_W'(1);
               if (settle_cnt == CNT_LAST) begin
                  state <= SAMPLE;
               end
            end

            SAMPLE: begin
               if (mismatch) begin
                  if (err_cnt != '1) begin
                     err_cnt <= err_cnt + ERR_W'(1);
                  end
                  if (!first_fail_valid) begin
                     first_fail_vec   <= vec;
                     first_fail_valid <= 1'b1;
                  end
               end
               if (vec == VEC_LAST) begin
                  // done is registered, so it is raised on the edge entering DONE.
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  vec   <= vec + N_IN'(1);
                  state <= DRIVE;
               end
            end

            DONE: begin
               // err_cnt already includes the final sample taken on the edge
               // that entered DONE.
               pass  <= (err_cnt == '0);
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker. Four checker instances with different
// parameters each drive their own gate model (a real OR or a truth table),
// and results are compared against a sweep-level reference model.
module tb_gate_checker;
   import gate_check_pkg::*;

   localparam int NK = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       start     [NK];
   logic [1:0] din       [NK];
   logic       y         [NK];
   logic       busy_w    [NK];
   logic       done_w    [NK];
   logic       pass_w    [NK];
   logic       ffvalid_w [NK];
   logic [1:0] ffv_w     [NK];
   logic [3:0] err_w     [NK];
   logic [3:0] err0, err2, err3;
   logic       err1;

   bit         use_or [NK];
   logic [3:0] tt     [NK];

   int n_run  = 0;
   int n_fail = 0;

   // Gate under test per instance: a real 2-input OR, or an arbitrary table.
   always_comb begin
      for (int k = 0; k < NK; k++) begin
         y[k] = use_or[k] ? (din[k][1] | din[k][0]) : tt[k][din[k]];
      end
   end

   always_comb begin
      err_w[0] = err0;
      err_w[1] = {3'b000, err1};
      err_w[2] = err2;
      err_w[3] = err3;
   end

   gate_checker #(.SETTLE(1)) u0 (
      .clk(clk), .reset_n(reset_n), .start(start[0]), .dut_in(din[0]), .dut_y(y[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err0),
      .first_fail_vec(ffv_w[0]), .first_fail_valid(ffvalid_w[0]));

   gate_checker #(.SETTLE(1), .ERR_W(1)) u1 (
      .clk(clk), .reset_n(reset_n), .start(start[1]), .dut_in(din[1]), .dut_y(y[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err1),
      .first_fail_vec(ffv_w[1]), .first_fail_valid(ffvalid_w[1]));

   gate_checker #(.SETTLE(0)) u2 (
      .clk(clk), .reset_n(reset_n), .start(start[2]), .dut_in(din[2]), .dut_y(y[2]),
      .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err2),
      .first_fail_vec(ffv_w[2]), .first_fail_valid(ffvalid_w[2]));

   gate_checker #(.SETTLE(3)) u3 (
      .clk(clk), .reset_n(reset_n), .start(start[3]), .dut_in(din[3]), .dut_y(y[3]),
      .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_cnt(err3),
      .first_fail_vec(ffv_w[3]), .first_fail_valid(ffvalid_w[3]));

   function automatic int settle_of(input int k);
      case (k)
         2:       return 0;
         3:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int errmax_of(input int k);
      return (k == 1) ? 1 : 15;
   endfunction

   // Reference: compare the gate's full truth table against OR, vector by vector.
   function automatic void model(input logic [3:0] gate_tt, input int emax,
                                 output int e_cnt, output int e_first,
                                 output bit e_valid, output bit e_pass);
      int n;
      n       = 0;
      e_first = 0;
      e_valid = 1'b0;
      for (int v = 0; v < 4; v++) begin
         // OR of the two input bits of vector v
         if (gate_tt[v] !== ((v != 0) ? 1'b1 : 1'b0)) begin
            if (!e_valid) begin
               e_first = v;
               e_valid = 1'b1;
            end
            n++;
         end
      end
      e_cnt  = (n > emax) ? emax : n;
      e_pass = (n == 0);
   endfunction

   // Start a sweep on instance k and follow it to the IDLE cycle after done.
   // lat is the 1-based cycle (after the accept edge) in which done is seen.
   task automatic run_sweep(input int k, input int pulse_at, output int lat,
                            output bit seq_ok, output bit busy_ok, output bit tail_ok);
      int         cnt;
      logic [1:0] q[$];
      lat     = -1;
      busy_ok = 1'b1;
      @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      cnt = 1;
      while (cnt <= 200) begin
         if (busy_w[k] !== 1'b1) busy_ok = 1'b0;
         if (cnt >= 2 && (q.size() == 0 || q[$] !== din[k])) q.push_back(din[k]);
         if (done_w[k] === 1'b1) begin
            lat = cnt;
            break;
         end
         @(negedge clk);
         cnt++;
         start[k] = (cnt == pulse_at);
      end
      start[k] = 1'b0;
      seq_ok = (q.size() == 4) && (q[0] === 2'd0) && (q[1] === 2'd1) &&
               (q[2] === 2'd2) && (q[3] === 2'd3);
      @(negedge clk);
      tail_ok = (done_w[k] === 1'b0) && (busy_w[k] === 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         n_run++;
         if ({din[k], busy_w[k], done_w[k], pass_w[k], err_w[k], ffvalid_w[k], ffv_w[k]} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_values k=%0d: got din=%b busy=%b done=%b pass=%b err=%0d valid=%b vec=%b, expected all 0",
                     k, din[k], busy_w[k], done_w[k], pass_w[k], err_w[k], ffvalid_w[k], ffv_w[k]);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One full sweep on instance k with gate table gt (or a real OR) and all
   // result checks against the model.
   task automatic test_sweep(input string name, input int k, input bit real_or,
                             input logic [3:0] gt, input int pulse_at);
      int lat, e_cnt, e_first;
      bit seq_ok, busy_ok, tail_ok, e_valid, e_pass;
      logic [7:0] got, exp;
      use_or[k] = real_or;
      tt[k]     = gt;
      model(real_or ? TT_OR2 : gt, errmax_of(k), e_cnt, e_first, e_valid, e_pass);
      run_sweep(k, pulse_at, lat, seq_ok, busy_ok, tail_ok);
      n_run++;
      if (lat !== (2 + settle_of(k)) * 4 + 1) begin
         n_fail++;
         $display("FAIL %s_latency k=%0d: got %0d expected %0d", name, k, lat, (2 + settle_of(k)) * 4 + 1);
      end
      got = {pass_w[k], err_w[k], ffvalid_w[k], ffv_w[k]};
      exp = {e_pass, 4'(e_cnt), e_valid, 2'(e_first)};
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s_result k=%0d gate=%b: got pass,err,valid,vec=%b expected %b", name, k, gt, got, exp);
      end
      n_run++;
      if (!(seq_ok && busy_ok && tail_ok)) begin
         n_fail++;
         $display("FAIL %s_sequence k=%0d: got seq=%0d busy=%0d single_done=%0d expected 1 1 1",
                  name, k, seq_ok, busy_ok, tail_ok);
      end
   endtask

   task automatic test_or_default();
      test_sweep("or_default", 0, 1'b1, 4'b0000, 0);
   endtask

   task automatic test_and_dut();
      test_sweep("and_dut", 0, 1'b0, TT_AND2, 0);
   endtask

   task automatic test_stuck_saturate();
      test_sweep("stuck0", 1, 1'b0, 4'b0000, 0);
      test_sweep("stuck0_recover", 1, 1'b1, 4'b0000, 0);
   endtask

   task automatic test_settle();
      test_sweep("settle0", 2, 1'b1, 4'b0000, 0);
      test_sweep("settle0_xor", 2, 1'b0, TT_XOR2, 0);
      test_sweep("settle3", 3, 1'b1, 4'b0000, 0);
      test_sweep("settle3_nand", 3, 1'b0, TT_NAND2, 0);
   endtask

   task automatic test_start_while_busy();
      test_sweep("start_busy", 0, 1'b1, 4'b0000, 5);
   endtask

   task automatic test_reset_mid();
      bit saw_done;
      use_or[0] = 1'b0;
      tt[0]     = TT_AND2;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (7) @(negedge clk);
      // Cycle 8: SETTLE of vector 2, one mismatch (vector 1) recorded so far.
      n_run++;
      if ({din[0], err_w[0], busy_w[0]} !== {2'd2, 4'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_before: got din=%0d err=%0d busy=%b expected din=2 err=1 busy=1",
                  din[0], err_w[0], busy_w[0]);
      end
      #2 reset_n = 1'b0;
      #1;
      n_run++;
      if ({din[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ffvalid_w[0], ffv_w[0]} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got din=%b busy=%b done=%b pass=%b err=%0d valid=%b vec=%b, expected all 0",
                  din[0], busy_w[0], done_w[0], pass_w[0], err_w[0], ffvalid_w[0], ffv_w[0]);
      end
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done_w[0] !== 1'b0) saw_done = 1'b1;
      end
      reset_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) saw_done = 1'b1;
      end
      n_run++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: got done/busy activity after abort, expected none");
      end
      test_sweep("after_reset", 0, 1'b1, 4'b0000, 0);
   endtask

   task automatic test_back_to_back();
      int cnt, n_done, first_at, second_at;
      use_or[0] = 1'b1;
      n_done    = 0;
      first_at  = -1;
      second_at = -1;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      cnt = 1;
      while (cnt <= 80 && n_done < 2) begin
         if (done_w[0] === 1'b1) begin
            n_done++;
            if (n_done == 1) first_at = cnt;
            else second_at = cnt;
         end
         if (n_done == 2) start[0] = 1'b0;
         else begin
            @(negedge clk);
            cnt++;
         end
      end
      start[0] = 1'b0;
      @(negedge clk);
      n_run++;
      if (first_at !== 13 || second_at !== 27) begin
         n_fail++;
         $display("FAIL back_to_back_timing: got done at %0d and %0d expected 13 and 27", first_at, second_at);
      end
      n_run++;
      if ({busy_w[0], pass_w[0], err_w[0]} !== {1'b0, 1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL back_to_back_result: got busy=%b pass=%b err=%0d expected busy=0 pass=1 err=0",
                  busy_w[0], pass_w[0], err_w[0]);
      end
   endtask

   task automatic test_random();
      int k;
      logic [3:0] gt;
      for (int i = 0; i < 24; i++) begin
         k  = $urandom_range(0, NK - 1);
         gt = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         test_sweep("random", k, 1'b0, gt, 0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < NK; k++) begin
         start[k]  = 1'b0;
         use_or[k] = 1'b1;
         tt[k]     = 4'b0000;
      end
      test_reset();
      test_or_default();
      test_and_dut();
      test_stuck_saturate();
      test_settle();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_checker.md
Name: gate_checker

Overview:
Synthesizable built-in checker for 2-input (generally N-input) combinational gates such as logic_or. It is the hardware counterpart of the stimulus bench. On start, it sweeps every input vector into the gate under test and waits a settle interval. It then samples the gate output, compares it with a parameterised truth table, and reports pass/fail, an error count and the first failing vector.

Parameters:
N_IN, 2, number of gate inputs; the sweep covers 2**N_IN vectors
SETTLE, 1, clock cycles between driving a vector and sampling dut_y (0 allowed)
EXPECT, 4'b1110 (OR), truth table of width 2**N_IN; bit i is the expected y for vector i
ERR_W, 4, width of the error counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin a sweep; sampled only in IDLE
dut_in  output  N_IN  registered vector to the gate; for N_IN=2, a=dut_in[1], b=dut_in[0]
dut_y  input  1  gate output under test
busy  output  1  high from the cycle after start is accepted until DONE exits
done  output  1  one-cycle pulse at end of sweep
pass  output  1  held; 1 when the last sweep had zero mismatches
err_cnt  output  ERR_W  mismatch count of the last/current sweep, saturating
first_fail_vec  output  N_IN  first mismatching vector of the sweep
first_fail_valid  output  1  first_fail_vec is meaningful

Behaviour:
- Reset values:
  - Async assert: all outputs 0, state IDLE, vec=0, settle counter 0.
  - Reset mid-sweep aborts immediately with no done pulse.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - When start=1, go to DRIVE.
  - On the same edge: vec<=0, err_cnt<=0, pass<=0, first_fail_valid<=0, first_fail_vec<=0.
- DRIVE: dut_in<=vec; settle counter <=0. Next state is SETTLE if SETTLE>0, else SAMPLE.
- SETTLE:
  - The counter increments each cycle.
  - After exactly SETTLE cycles in this state, go to SAMPLE.
- SAMPLE:
  - Compute mismatch = dut_y != EXPECT[vec].
  - On mismatch: err_cnt increments, saturating at 2**ERR_W-1.
  - On mismatch with first_fail_valid=0: latch first_fail_vec<=vec and set first_fail_valid<=1.
  - If vec == 2**N_IN-1, go to DONE; else vec<=vec+1 and go to DRIVE.
  - No wrap of vec within a sweep.
- DONE:
  - done=1 for exactly this cycle.
  - pass<=(err_cnt==0 including this sweep's final sample).
  - Return to IDLE.
- Outputs from the previous sweep persist in IDLE until the next start is accepted.
- busy=1 in DRIVE, SETTLE, SAMPLE and DONE; 0 in IDLE.
- start is ignored in every state except IDLE.
- start held high re-arms immediately: the next sweep begins the cycle after DONE.
- Latency from start-accept edge to the done cycle is (2+SETTLE)*2**N_IN + 1 cycles. With defaults this is 13.
- dut_y is treated as combinational from dut_in; it is not synchronised.
- dut_in holds the last vector after the sweep and returns to 0 only on reset.

Decomposition:
- Package gate_check_pkg holds:
  - state enum typedef state_t {IDLE, DRIVE, SETTLE, SAMPLE, DONE};
  - truth-table constants TT_OR2=4'b1110, TT_AND2=4'b1000, TT_XOR2=4'b0110, TT_NAND2=4'b0111.
- No sub-module: the vector counter, settle counter and comparator stay inline in one FSM module.
- The bench wraps logic_or (or a faulty model) as the DUT.

Test Plan:
1. Defaults with a real logic_or wired in; start pulse -> dut_in sequence 00,01,10,11; done exactly 13 cycles after start accept; pass=1, err_cnt=0, first_fail_valid=0.
2. EXPECT=TT_OR2 with an AND gate as DUT -> mismatches at vectors 1 and 2; err_cnt=2, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
3. Faulty DUT with dut_y stuck at 0, ERR_W=1 -> 3 mismatches saturate err_cnt at 1, first_fail_vec=2'b01, pass=0; then a second sweep with the correct DUT -> err_cnt=0, pass=1.
4. SETTLE=0 -> done 9 cycles after start; SETTLE=3 -> 21 cycles. dut_y must be sampled no earlier than the cycle after dut_in changes.
5. start pulsed while busy=1 (mid-sweep) -> ignored: no restart, same done timing and results as scenario 1.
6. reset_n pulled low during SETTLE of vector 2 -> all outputs 0 asynchronously, no done pulse; a following start runs a clean full sweep with pass=1.
